// File: rtl/demux_stream_1xn.sv
// ---------------------------------------------------------------------------
// demux_stream_1xn
//   Registered 1-to-N stream demultiplexer with valid/ready backpressure,
//   optional per-packet select locking, and dropping of beats whose select
//   does not name an existing channel (counted by a saturating counter).
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream beat valid
//   in_ready   upstream beat accepted when in_valid && in_ready
//   in_data    upstream payload
//   in_sel     destination channel
//   in_last    last beat of packet
//   out_valid  per-channel valid (one-hot or zero)
//   out_ready  per-channel downstream ready
//   out_data   payload, shared by all channels
//   out_last   last flag of the registered beat
//   busy       a packet is locked
//   drop_cnt   saturating count of dropped beats
//
// State table (only used when PKT_MODE != 0)
//   state  | meaning
//   IDLE   | between packets, select taken from in_sel
//   LOCKED | inside a packet, select taken from lock_sel_q
// ---------------------------------------------------------------------------
module demux_stream_1xn #(
  parameter int DATA_W     = 8,
  parameter int N_CH       = 8,
  parameter int SEL_W      = 3,
  parameter int PKT_MODE   = 1,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_last,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_LOCKED = 1'b1;
  localparam logic [31:0] N_CH_U    = 32'(N_CH);

  logic [0:0]            state_q, state_d;
  logic [SEL_W-1:0]      lock_sel_q, lock_sel_d;
  logic                  vld_q, vld_d;
  logic [SEL_W-1:0]      ch_q, ch_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  last_q, last_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [SEL_W-1:0]      esel;
  logic                  routable;
  logic                  ch_ready;
  logic                  held_done;
  logic                  accept;
  logic                  load;
  logic                  drop;

  // Inside a locked packet the stored select wins; in_sel is ignored.
  assign esel     = (PKT_MODE != 0 && state_q == ST_LOCKED) ? lock_sel_q : in_sel;
  assign routable = (32'(esel) < N_CH_U);

  // Decode the held channel into per-channel valid and pick its ready.
  always_comb begin
    out_valid = '0;
    ch_ready  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      out_valid[i] = vld_q && (ch_q == SEL_W'(i));
      if (ch_q == SEL_W'(i)) ch_ready = out_ready[i];
    end
  end

  assign held_done = vld_q && ch_ready;
  // Drops never touch the register, so they are never backpressured.
  assign in_ready  = routable ? (!vld_q || ch_ready) : 1'b1;
  assign accept    = in_valid && in_ready;
  assign load      = accept && routable;
  assign drop      = accept && !routable;

  // Output register: a load takes priority over completion so that a
  // departing beat and an arriving beat share one edge.
  always_comb begin
    vld_d  = vld_q;
    ch_d   = ch_q;
    data_d = data_q;
    last_d = last_q;
    if (load) begin
      vld_d  = 1'b1;
      ch_d   = esel;
      data_d = in_data;
      last_d = in_last;
    end else if (held_done) begin
      vld_d  = 1'b0;
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  // Invalid selects lock too, so the rest of such a packet is dropped.
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    if (PKT_MODE != 0 && accept) begin
      if (in_last) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_LOCKED;
        if (state_q == ST_IDLE) lock_sel_d = in_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lock_sel_q <= '0;
      vld_q      <= 1'b0;
      ch_q       <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      vld_q      <= vld_d;
      ch_q       <= ch_d;
      data_q     <= data_d;
      last_q     <= last_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_data = data_q;
  assign out_last = last_q;
  assign busy     = (state_q == ST_LOCKED);
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream_1xn.sv
module tb_demux_stream_1xn;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last;
  logic [2:0] in_sel;
  logic [7:0] in_data;
  logic [7:0] out_ready;

  always #5 clk = ~clk;

  // a: stream mode, 8 ch | b: packet mode, 8 ch
  // c: packet mode, 6 ch | d: stream mode, 6 ch, 2-bit drop counter
  logic       a_ir, a_ol, a_busy; logic [7:0] a_ov, a_od, a_drop;
  logic       b_ir, b_ol, b_busy; logic [7:0] b_ov, b_od, b_drop;
  logic       c_ir, c_ol, c_busy; logic [5:0] c_ov; logic [7:0] c_od, c_drop;
  logic       d_ir, d_ol, d_busy; logic [5:0] d_ov; logic [7:0] d_od; logic [1:0] d_drop;

  demux_stream_1xn #(.DATA_W(8), .N_CH(8), .SEL_W(3), .PKT_MODE(0), .DROP_CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ir), .in_data(in_data),
    .in_sel(in_sel), .in_last(in_last), .out_valid(a_ov), .out_ready(out_ready),
    .out_data(a_od), .out_last(a_ol), .busy(a_busy), .drop_cnt(a_drop));

  demux_stream_1xn #(.DATA_W(8), .N_CH(8), .SEL_W(3), .PKT_MODE(1), .DROP_CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ir), .in_data(in_data),
    .in_sel(in_sel), .in_last(in_last), .out_valid(b_ov), .out_ready(out_ready),
    .out_data(b_od), .out_last(b_ol), .busy(b_busy), .drop_cnt(b_drop));

  demux_stream_1xn #(.DATA_W(8), .N_CH(6), .SEL_W(3), .PKT_MODE(1), .DROP_CNT_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_ir), .in_data(in_data),
    .in_sel(in_sel), .in_last(in_last), .out_valid(c_ov), .out_ready(out_ready[5:0]),
    .out_data(c_od), .out_last(c_ol), .busy(c_busy), .drop_cnt(c_drop));

  demux_stream_1xn #(.DATA_W(8), .N_CH(6), .SEL_W(3), .PKT_MODE(0), .DROP_CNT_W(2)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_ir), .in_data(in_data),
    .in_sel(in_sel), .in_last(in_last), .out_valid(d_ov), .out_ready(out_ready[5:0]),
    .out_data(d_od), .out_last(d_ol), .busy(d_busy), .drop_cnt(d_drop));

  // View of the instance under test.
  int         sel_dut;
  logic       m_ir, m_ol, m_busy;
  logic [7:0] m_ov, m_od, m_drop;

  always_comb begin
    m_ir = a_ir; m_ol = a_ol; m_busy = a_busy; m_ov = a_ov; m_od = a_od; m_drop = a_drop;
    case (sel_dut)
      1: begin m_ir = b_ir; m_ol = b_ol; m_busy = b_busy; m_ov = b_ov; m_od = b_od; m_drop = b_drop; end
      2: begin m_ir = c_ir; m_ol = c_ol; m_busy = c_busy; m_ov = {2'b00, c_ov}; m_od = c_od; m_drop = c_drop; end
      3: begin m_ir = d_ir; m_ol = d_ol; m_busy = d_busy; m_ov = {2'b00, d_ov}; m_od = d_od; m_drop = {6'b0, d_drop}; end
      default: ;
    endcase
  end

  int n_pass  = 0;
  int n_total = 0;
  int stalls  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    int         ch;
    logic [7:0] d;
    logic       l;
  } beat_t;
  beat_t sb[$];

  // Scoreboard: a beat completes at the edge following a negedge where it is
  // valid on its channel and that channel is ready.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 8; i++) begin
        if (m_ov[i] && out_ready[i]) begin
          if (sb.size() == 0) begin
            n_total++;
            $display("FAIL sb_underflow: beat on ch %0d data %0h, none expected", i, m_od);
          end else begin
            beat_t e;
            e = sb.pop_front();
            chk("sb_ch", 32'(i), 32'(e.ch));
            chk("sb_data", 32'(m_od), 32'(e.d));
            chk("sb_last", 32'(m_ol), 32'(e.l));
          end
        end
      end
    end
  end

  // Drive a beat (called at posedge+2), wait for acceptance, return at the
  // posedge+2 after the accepting edge. exp_ch < 0 means a dropped beat.
  task automatic send(input logic [2:0] s, input logic [7:0] d, input logic l, input int exp_ch);
    int    n;
    beat_t b;
    in_valid = 1'b1; in_sel = s; in_data = d; in_last = l;
    n = 0;
    @(negedge clk);
    while (!m_ir && n < 20) begin
      n++;
      @(negedge clk);
    end
    stalls = n;
    if (!m_ir) begin
      n_total++;
      $display("FAIL send_timeout: in_ready low for sel %0d data %0h", s, d);
    end else if (exp_ch >= 0) begin
      b.ch = exp_ch; b.d = d; b.l = l;
      sb.push_back(b);
    end
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    repeat (2) begin @(posedge clk); #2; end
    rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    logic       last;
    logic [7:0] exp_ov;
    logic [7:0] exp_od;
  } vec_t;

  vec_t vecs[8];
  int   sat_exp[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++)
      vecs[i] = '{sel: 3'(i), data: 8'hA0 + 8'(i), last: 1'b1,
                  exp_ov: 8'(1 << i), exp_od: 8'hA0 + 8'(i)};
    sat_exp = '{1, 2, 3, 3, 3};

    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; in_last = 1'b0;
    out_ready = 8'hFF; sel_dut = 0;
    #3;
    chk("rst_valid", 32'(m_ov), 0);
    chk("rst_data", 32'(m_od), 0);
    chk("rst_last", 32'(m_ol), 0);
    chk("rst_busy", 32'(b_busy), 0);
    chk("rst_drop", 32'(m_drop), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Sweep every channel back to back.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].sel, vecs[i].data, vecs[i].last, int'(vecs[i].sel));
      chk("sweep_stall", 32'(stalls), 0);
      chk("sweep_valid", 32'(m_ov), 32'(vecs[i].exp_ov));
      chk("sweep_data", 32'(m_od), 32'(vecs[i].exp_od));
    end
    idle(2);
    chk("sweep_sb_empty", 32'(sb.size()), 0);

    // Backpressure on channel 3, second beat to channel 5 must wait.
    out_ready = 8'hF7;
    send(3'd3, 8'h55, 1'b1, 3);
    in_valid = 1'b0;
    chk("bp_valid0", 32'(m_ov), 32'h08);
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(m_ov), 32'h08);
      chk("bp_hold_data", 32'(m_od), 32'h55);
    end
    @(posedge clk); #2;
    in_valid = 1'b1; in_sel = 3'd5; in_data = 8'h66; in_last = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_low", 32'(m_ir), 0);
    chk("bp_hold_valid2", 32'(m_ov), 32'h08);
    @(posedge clk); #2;
    out_ready = 8'hFF;
    @(negedge clk);
    chk("bp_in_ready_high", 32'(m_ir), 1);
    sb.push_back('{ch: 5, d: 8'h66, l: 1'b1});
    @(posedge clk); #2;
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(m_ov), 32'h20);
    chk("bp_next_data", 32'(m_od), 32'h66);
    idle(2);
    chk("bp_sb_empty", 32'(sb.size()), 0);

    // Packet lock: selects 2,6,7 all land on channel 2.
    do_reset();
    sel_dut = 1;
    send(3'd2, 8'h11, 1'b0, 2);
    chk("lock_busy1", 32'(m_busy), 1);
    chk("lock_valid1", 32'(m_ov), 32'h04);
    send(3'd6, 8'h12, 1'b0, 2);
    chk("lock_busy2", 32'(m_busy), 1);
    chk("lock_valid2", 32'(m_ov), 32'h04);
    send(3'd7, 8'h13, 1'b1, 2);
    chk("lock_busy3", 32'(m_busy), 0);
    chk("lock_valid3", 32'(m_ov), 32'h04);
    chk("lock_last3", 32'(m_ol), 1);
    send(3'd6, 8'h21, 1'b1, 6);
    chk("lock_next_valid", 32'(m_ov), 32'h40);
    idle(2);
    chk("lock_sb_empty", 32'(sb.size()), 0);

    // Drops with six channels.
    do_reset();
    sel_dut = 2;
    send(3'd6, 8'h01, 1'b1, -1);
    chk("drop6_stall", 32'(stalls), 0);
    chk("drop6_valid", 32'(m_ov), 0);
    chk("drop6_cnt", 32'(m_drop), 1);
    send(3'd7, 8'h02, 1'b1, -1);
    chk("drop7_stall", 32'(stalls), 0);
    chk("drop7_valid", 32'(m_ov), 0);
    chk("drop7_cnt", 32'(m_drop), 2);
    send(3'd7, 8'h03, 1'b0, -1);
    chk("droppkt_busy", 32'(m_busy), 1);
    chk("droppkt_cnt1", 32'(m_drop), 3);
    send(3'd3, 8'h04, 1'b1, -1);
    chk("droppkt_valid", 32'(m_ov), 0);
    chk("droppkt_idle", 32'(m_busy), 0);
    chk("droppkt_cnt2", 32'(m_drop), 4);
    idle(1);

    // Drop counter saturation with a 2-bit counter.
    do_reset();
    sel_dut = 3;
    for (int i = 0; i < 5; i++) begin
      send(3'd6, 8'(i), 1'b1, -1);
      chk("sat_cnt", 32'(m_drop), 32'(sat_exp[i]));
    end
    idle(1);

    // Asynchronous reset while a packet is locked and a beat is held.
    do_reset();
    sel_dut = 2;
    send(3'd6, 8'h00, 1'b1, -1);
    out_ready = 8'h00;
    send(3'd4, 8'h77, 1'b0, 4);
    in_valid = 1'b0;
    chk("arst_pre_drop", 32'(m_drop), 1);
    chk("arst_pre_busy", 32'(m_busy), 1);
    chk("arst_pre_valid", 32'(m_ov), 32'h10);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_valid", 32'(m_ov), 0);
    chk("arst_busy", 32'(m_busy), 0);
    chk("arst_drop", 32'(m_drop), 0);
    chk("arst_data", 32'(m_od), 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    out_ready = 8'hFF;
    send(3'd1, 8'h31, 1'b1, 1);
    chk("arst_after_valid", 32'(m_ov), 32'h02);
    chk("arst_after_data", 32'(m_od), 32'h31);
    idle(2);
    chk("arst_sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
